// File: rtl/csr_unit.sv
// Machine/supervisor CSR file with trap, mret and sret sequencing; reads and trap are combinational, updates land on the next clock.
// No flow control: every event strobe is accepted in the cycle it is presented.
module csr_unit #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [11:0]          addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 external_interrupt,
    input  logic                 mem_msip,
    input  logic                 mem_ssip,
    input  logic [DATA_SIZE-1:0] pc,
    input  logic [63:0]          mem_mtime,
    input  logic [63:0]          mem_mtimecmp,
    input  logic                 illegal_instruction,
    input  logic                 ecall,
    input  logic                 mret,
    input  logic                 sret,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic [DATA_SIZE-1:0] mepc,
    output logic [DATA_SIZE-1:0] sepc,
    output logic                 trap,
    output logic [1:0]           privilege_mode
);
    localparam int XLEN = DATA_SIZE;
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MIE    = 12'h304, A_MTVEC  = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC   = 12'h341, A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344, A_SSTATUS = 12'h100, A_SIE   = 12'h104;
    localparam logic [11:0] A_STVEC    = 12'h105, A_SSCRATCH = 12'h140, A_SEPC = 12'h141;
    localparam logic [11:0] A_SCAUSE   = 12'h142, A_SIP    = 12'h144;
    localparam logic [11:0] S_IE_MASK  = 12'h222;
    localparam logic [11:0] M_IE_MASK  = 12'hAAA;

    logic [1:0]      priv_q, priv_d, mpp_q, mpp_d;
    logic            sie_q, sie_d, mie_q, mie_d, spie_q, spie_d, mpie_q, mpie_d, spp_q, spp_d;
    logic [11:0]     ie_q, ie_d;
    logic            stip_q, stip_d, seip_q, seip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, stvec_q, stvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] sscratch_q, sscratch_d, mepc_q, mepc_d, sepc_q, sepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, scause_q, scause_d;

    logic            mtip, sync_exc, int_en;
    logic [11:0]     mip_val, pend;
    logic [3:0]      int_code;
    logic [XLEN-1:0] mstatus_val, sstatus_val, cause;

    assign mtip    = (mem_mtime >= mem_mtimecmp);
    assign mip_val = {external_interrupt, 1'b0, seip_q, 1'b0, mtip, 1'b0,
                      stip_q, 1'b0, mem_msip, 1'b0, mem_ssip, 1'b0};
    assign pend    = mip_val & ie_q;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[1]     = sie_q;
        mstatus_val[3]     = mie_q;
        mstatus_val[5]     = spie_q;
        mstatus_val[7]     = mpie_q;
        mstatus_val[8]     = spp_q;
        mstatus_val[12:11] = mpp_q;
        sstatus_val        = '0;
        sstatus_val[1]     = sie_q;
        sstatus_val[5]     = spie_q;
        sstatus_val[8]     = spp_q;
    end

    // Interrupts are globally masked only while running in M mode with MIE clear.
    always_comb begin
        int_code = 4'd0;
        if (pend[11])     int_code = 4'd11;
        else if (pend[3]) int_code = 4'd3;
        else if (pend[7]) int_code = 4'd7;
        else if (pend[9]) int_code = 4'd9;
        else if (pend[1]) int_code = 4'd1;
        else if (pend[5]) int_code = 4'd5;
        sync_exc = illegal_instruction | ecall;
        int_en   = (|pend) && (priv_q != 2'b11 || mie_q);
        if (illegal_instruction)
            cause = {{(XLEN-4){1'b0}}, 4'd2};
        else if (ecall)
            cause = {{(XLEN-4){1'b0}}, 4'd8 + {2'b00, priv_q}};
        else
            cause = {1'b1, {(XLEN-5){1'b0}}, int_code};
    end

    always_comb begin
        trap           = sync_exc | int_en;
        mepc           = mepc_q;
        sepc           = sepc_q;
        privilege_mode = priv_q;
        case (addr)
            A_MSTATUS:  rd_data = mstatus_val;
            A_MIE:      rd_data = {{(XLEN-12){1'b0}}, ie_q};
            A_MTVEC:    rd_data = mtvec_q;
            A_MSCRATCH: rd_data = mscratch_q;
            A_MEPC:     rd_data = mepc_q;
            A_MCAUSE:   rd_data = mcause_q;
            A_MIP:      rd_data = {{(XLEN-12){1'b0}}, mip_val};
            A_SSTATUS:  rd_data = sstatus_val;
            A_SIE:      rd_data = {{(XLEN-12){1'b0}}, ie_q & S_IE_MASK};
            A_STVEC:    rd_data = stvec_q;
            A_SSCRATCH: rd_data = sscratch_q;
            A_SEPC:     rd_data = sepc_q;
            A_SCAUSE:   rd_data = scause_q;
            A_SIP:      rd_data = {{(XLEN-12){1'b0}}, mip_val & S_IE_MASK};
            default:    rd_data = '0;
        endcase
    end

    // Priority: trap, then mret, then sret, then a plain CSR write.
    always_comb begin
        priv_d = priv_q;  mpp_d = mpp_q;  sie_d = sie_q;  mie_d = mie_q;
        spie_d = spie_q;  mpie_d = mpie_q; spp_d = spp_q; ie_d = ie_q;
        stip_d = stip_q;  seip_d = seip_q; mtvec_d = mtvec_q; stvec_d = stvec_q;
        mscratch_d = mscratch_q; sscratch_d = sscratch_q;
        mepc_d = mepc_q; sepc_d = sepc_q; mcause_d = mcause_q; scause_d = scause_q;
        if (trap) begin
            mepc_d   = pc;
            mcause_d = cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = priv_q;
            priv_d   = 2'b11;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            priv_d = mpp_q;
        end else if (sret) begin
            sie_d  = spie_q;
            spie_d = 1'b1;
            priv_d = {1'b0, spp_q};
            spp_d  = 1'b1;
        end else if (wr_en) begin
            case (addr)
                A_MSTATUS: begin
                    sie_d = wr_data[1];  mie_d = wr_data[3];  spie_d = wr_data[5];
                    mpie_d = wr_data[7]; spp_d = wr_data[8];
                    if (wr_data[12:11] != 2'b10) mpp_d = wr_data[12:11];
                end
                A_SSTATUS: begin
                    sie_d = wr_data[1]; spie_d = wr_data[5]; spp_d = wr_data[8];
                end
                A_MIE:      ie_d = wr_data[11:0] & M_IE_MASK;
                A_SIE:      ie_d = (ie_q & ~S_IE_MASK) | (wr_data[11:0] & S_IE_MASK);
                A_MIP, A_SIP: begin
                    stip_d = wr_data[5]; seip_d = wr_data[9];
                end
                A_MTVEC:    mtvec_d    = wr_data;
                A_STVEC:    stvec_d    = wr_data;
                A_MSCRATCH: mscratch_d = wr_data;
                A_SSCRATCH: sscratch_d = wr_data;
                A_MEPC:     mepc_d     = {wr_data[XLEN-1:2], 2'b00};
                A_SEPC:     sepc_d     = {wr_data[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = wr_data;
                A_SCAUSE:   scause_d   = wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            priv_q <= 2'b11; mpp_q <= '0; sie_q <= 1'b0; mie_q <= 1'b0;
            spie_q <= 1'b0; mpie_q <= 1'b0; spp_q <= 1'b0; ie_q <= '0;
            stip_q <= 1'b0; seip_q <= 1'b0; mtvec_q <= '0; stvec_q <= '0;
            mscratch_q <= '0; sscratch_q <= '0; mepc_q <= '0; sepc_q <= '0;
            mcause_q <= '0; scause_q <= '0;
        end else begin
            priv_q <= priv_d; mpp_q <= mpp_d; sie_q <= sie_d; mie_q <= mie_d;
            spie_q <= spie_d; mpie_q <= mpie_d; spp_q <= spp_d; ie_q <= ie_d;
            stip_q <= stip_d; seip_q <= seip_d; mtvec_q <= mtvec_d; stvec_q <= stvec_d;
            mscratch_q <= mscratch_d; sscratch_q <= sscratch_d; mepc_q <= mepc_d;
            sepc_q <= sepc_d; mcause_q <= mcause_d; scause_q <= scause_d;
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Directed table plus hand sequences for trap, mret/sret and interrupt priority.
module tb_csr_unit;
    logic        clock = 1'b0;
    logic        reset, wr_en, external_interrupt, mem_msip, mem_ssip;
    logic        illegal_instruction, ecall, mret, sret, trap;
    logic [11:0] addr;
    logic [31:0] wr_data, pc, rd_data, mepc, sepc;
    logic [63:0] mem_mtime, mem_mtimecmp;
    logic [1:0]  privilege_mode;
    int          errors = 0, checks = 0;

    localparam logic [11:0] MSTATUS = 12'h300, MIE = 12'h304, MTVEC = 12'h305, MSCRATCH = 12'h340;
    localparam logic [11:0] MEPC = 12'h341, MCAUSE = 12'h342, MIP = 12'h344, SSTATUS = 12'h100;
    localparam logic [11:0] SIE = 12'h104, STVEC = 12'h105, SSCRATCH = 12'h140, SEPC = 12'h141;
    localparam logic [11:0] SCAUSE = 12'h142, SIP = 12'h144;

    csr_unit #(.DATA_SIZE(32)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .external_interrupt(external_interrupt), .mem_msip(mem_msip), .mem_ssip(mem_ssip),
        .pc(pc), .mem_mtime(mem_mtime), .mem_mtimecmp(mem_mtimecmp),
        .illegal_instruction(illegal_instruction), .ecall(ecall), .mret(mret), .sret(sret),
        .rd_data(rd_data), .mepc(mepc), .sepc(sepc), .trap(trap), .privilege_mode(privilege_mode));

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        bit          we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clock);
        addr = a; #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic pulse(input bit il, input bit ec, input bit mr, input bit sr,
                         input logic [31:0] p, input bit exp_trap);
        @(negedge clock);
        illegal_instruction = il; ecall = ec; mret = mr; sret = sr; pc = p;
        #1 chk("trap_on_event", trap, exp_trap);
        @(posedge clock); #1;
        illegal_instruction = 0; ecall = 0; mret = 0; sret = 0;
    endtask

    task automatic take_int(input logic [3:0] code);
        chk("int_trap", trap, 1);
        @(posedge clock); #1;
        chk("int_trap_cleared", trap, 0);
        rd("int_mcause", MCAUSE, {1'b1, 27'd0, code});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; wr_en = 0; addr = 0; wr_data = 0; pc = 0;
        external_interrupt = 0; mem_msip = 0; mem_ssip = 0;
        mem_mtime = 64'd0; mem_mtimecmp = '1;
        illegal_instruction = 0; ecall = 0; mret = 0; sret = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        vecs.push_back('{"mie_888",     1, MIE,      32'h888,      MIE,      32'h888});
        vecs.push_back('{"sie_222",     1, SIE,      32'h222,      SIE,      32'h222});
        vecs.push_back('{"mie_merged",  0, 12'h0,    32'h0,        MIE,      32'hAAA});
        vecs.push_back('{"mie_mask",    1, MIE,      32'hFFFFFFFF, MIE,      32'hAAA});
        vecs.push_back('{"sie_clear",   1, SIE,      32'h0,        MIE,      32'h888});
        vecs.push_back('{"sie_zero",    1, MIE,      32'h0,        SIE,      32'h0});
        vecs.push_back('{"mstat_ones",  1, MSTATUS,  32'hFFFFFFFF, MSTATUS,  32'h19AA});
        vecs.push_back('{"mpp_warl",    1, MSTATUS,  32'h1000,     MSTATUS,  32'h1800});
        vecs.push_back('{"sstat_wr",    1, SSTATUS,  32'hFFFFFFFF, MSTATUS,  32'h1922});
        vecs.push_back('{"sstat_rd",    0, 12'h0,    32'h0,        SSTATUS,  32'h122});
        vecs.push_back('{"mpp_01",      1, MSTATUS,  32'h0800,     MSTATUS,  32'h0800});
        vecs.push_back('{"mtvec",       1, MTVEC,    32'hDEADBEEF, MTVEC,    32'hDEADBEEF});
        vecs.push_back('{"stvec",       1, STVEC,    32'h00000103, STVEC,    32'h00000103});
        vecs.push_back('{"mscratch",    1, MSCRATCH, 32'h12345678, MSCRATCH, 32'h12345678});
        vecs.push_back('{"sscratch",    1, SSCRATCH, 32'hCAFEF00D, SSCRATCH, 32'hCAFEF00D});
        vecs.push_back('{"mcause",      1, MCAUSE,   32'h80000007, MCAUSE,   32'h80000007});
        vecs.push_back('{"scause",      1, SCAUSE,   32'hA5A5A5A5, SCAUSE,   32'hA5A5A5A5});
        vecs.push_back('{"sepc_align",  1, SEPC,     32'hFFFFFFFF, SEPC,     32'hFFFFFFFC});
        vecs.push_back('{"mepc_align",  1, MEPC,     32'h00001237, MEPC,     32'h00001234});
        vecs.push_back('{"unimpl",      1, 12'h7C0,  32'h0000FFFF, 12'h7C0,  32'h0});
        vecs.push_back('{"mip_wr",      1, MIP,      32'hFFFFFFFF, MIP,      32'h220});
        vecs.push_back('{"sip_rd",      0, 12'h0,    32'h0,        SIP,      32'h220});
        vecs.push_back('{"sip_clear",   1, SIP,      32'h0,        MIP,      32'h0});
        vecs.push_back('{"mstat_clr",   1, MSTATUS,  32'h0,        SSTATUS,  32'h0});

        do_reset();
        chk("reset_priv", privilege_mode, 2'b11);
        chk("reset_trap", trap, 0);
        chk("reset_mepc", mepc, 0);
        chk("reset_sepc", sepc, 0);
        rd("reset_mstatus", MSTATUS, 0);
        rd("reset_mtvec", MTVEC, 0);

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end
        chk("sepc_port", sepc, 32'hFFFFFFFC);

        // External interrupt in M mode; the concurrent CSR write must be dropped.
        do_reset();
        wr(MIE, 32'h800);
        wr(MSTATUS, 32'h888);
        rd("a_mstatus", MSTATUS, 32'h888);
        @(negedge clock);
        pc = 32'h100; external_interrupt = 1; wr_en = 1; addr = MSCRATCH; wr_data = 32'hFFFF;
        #1 chk("a_trap", trap, 1);
        @(posedge clock); #1;
        external_interrupt = 0; wr_en = 0;
        chk("a_trap_low", trap, 0);
        rd("a_mstatus_trap", MSTATUS, 32'h1880);
        rd("a_mcause", MCAUSE, 32'h8000000B);
        rd("a_mepc", MEPC, 32'h100);
        rd("a_mscratch_supp", MSCRATCH, 0);
        chk("a_priv", privilege_mode, 2'b11);
        pulse(0, 0, 1, 0, 32'h0, 0);
        rd("a_mstatus_mret", MSTATUS, 32'h1888);
        chk("a_priv_mret", privilege_mode, 2'b11);

        // sret into U, mret back to M, then a U-mode interrupt with MIE clear.
        do_reset();
        wr(SSTATUS, 32'h22);
        pulse(0, 0, 0, 1, 32'h0, 0);
        rd("b_sstatus", SSTATUS, 32'h122);
        chk("b_priv_u", privilege_mode, 2'b00);
        wr(MSTATUS, 32'h1922);
        pulse(0, 0, 1, 0, 32'h0, 0);
        chk("b_priv_m", privilege_mode, 2'b11);
        rd("b_mstatus", MSTATUS, 32'h19A2);
        wr(MSTATUS, 32'h0);
        pulse(0, 0, 1, 0, 32'h0, 0);
        chk("b_priv_u2", privilege_mode, 2'b00);
        wr(MIE, 32'h8);
        @(negedge clock);
        mem_msip = 1;
        #1 chk("b_u_int", trap, 1);
        @(posedge clock); #1;
        mem_msip = 0;
        rd("b_u_mcause", MCAUSE, 32'h80000003);
        chk("b_u_priv", privilege_mode, 2'b11);
        rd("b_u_mstatus", MSTATUS, 32'h0);

        // Live mip bits, MTIP compare edges, then full interrupt priority order.
        do_reset();
        wr(MIP, 32'h0);
        mem_ssip = 1; mem_msip = 1; mem_mtime = 64'd2; mem_mtimecmp = 64'd1; external_interrupt = 1;
        rd("c_mip", MIP, 32'h88A);
        chk("c_no_trap", trap, 0);
        wr(SIP, 32'h220);
        rd("c_sip", SIP, 32'h222);
        rd("c_mip_all", MIP, 32'hAAA);
        mem_mtime = 64'd5; mem_mtimecmp = 64'd5;
        rd("c_mtip_eq", MIP, 32'hAAA);
        mem_mtimecmp = 64'd6;
        rd("c_mtip_lt", MIP, 32'hA2A);
        mem_mtime = 64'h1_0000_0000; mem_mtimecmp = 64'h0_FFFF_FFFF;
        rd("c_mtip_hi", MIP, 32'hAAA);
        mem_mtime = 64'd2; mem_mtimecmp = 64'd1;
        wr(MIE, 32'hAAA);
        chk("c_m_masked", trap, 0);
        wr(MSTATUS, 32'h1808); take_int(4'd11); external_interrupt = 0;
        wr(MSTATUS, 32'h1808); take_int(4'd3);  mem_msip = 0;
        wr(MSTATUS, 32'h1808); take_int(4'd7);  mem_mtime = 64'd0;
        wr(MSTATUS, 32'h1808); take_int(4'd9);  wr(SIP, 32'h020);
        wr(MSTATUS, 32'h1808); take_int(4'd1);  mem_ssip = 0;
        wr(MSTATUS, 32'h1808); take_int(4'd5);  wr(SIP, 32'h0);

        // Synchronous exceptions and simultaneous-event priority.
        do_reset();
        pulse(0, 1, 0, 0, 32'hAA, 1);
        rd("d_mepc", MEPC, 32'hAA);
        chk("d_mepc_port", mepc, 32'hAA);
        rd("d_mcause_ecall", MCAUSE, 32'd11);
        wr(MEPC, 32'hFFFFFFFF);
        rd("d_mepc_align", MEPC, 32'hFFFFFFFC);
        pulse(1, 0, 0, 0, 32'h10, 1);
        rd("d_mcause_ill", MCAUSE, 32'd2);
        wr(MCAUSE, 32'd5);
        rd("d_mcause_wr", MCAUSE, 32'd5);
        pulse(1, 1, 0, 0, 32'h14, 1);
        rd("d_ill_over_ecall", MCAUSE, 32'd2);
        wr(MSTATUS, 32'h0800);
        pulse(0, 0, 1, 0, 32'h0, 0);
        chk("d_priv_s", privilege_mode, 2'b01);
        pulse(0, 1, 0, 0, 32'h20, 1);
        rd("d_mcause_s", MCAUSE, 32'd9);
        rd("d_mstatus_s", MSTATUS, 32'h0800);
        chk("d_priv_trap", privilege_mode, 2'b11);
        pulse(0, 1, 1, 0, 32'h24, 1);
        chk("d_trap_beats_mret", privilege_mode, 2'b11);
        rd("d_mstatus_tm", MSTATUS, 32'h1800);
        @(negedge clock);
        mret = 1; sret = 1; wr_en = 1; addr = MSCRATCH; wr_data = 32'h1;
        #1 chk("d_mret_no_trap", trap, 0);
        @(posedge clock); #1;
        mret = 0; sret = 0; wr_en = 0;
        chk("d_mret_beats_sret", privilege_mode, 2'b11);
        rd("d_sstatus_kept", SSTATUS, 32'h0);
        rd("d_mscratch_supp", MSCRATCH, 32'h0);
        rd("d_mstatus_mret", MSTATUS, 32'h1880);
        rd("d_scause", SCAUSE, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 DATA_SIZE, 32, register width XLEN (32 or 64); all XLEN-wide ports and CSRs use it.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  CSR write strobe for the CSR at addr.
REQ-006 addr  in  12  CSR address for read and write.
REQ-007 wr_data  in  XLEN  CSR write data.
REQ-008 external_interrupt  in  1  machine external interrupt level (MEIP).
REQ-009 mem_msip  in  1  machine software interrupt level (MSIP).
REQ-010 mem_ssip  in  1  supervisor software interrupt level (SSIP).
REQ-011 pc  in  XLEN  PC of the current instruction; captured on trap.
REQ-012 mem_mtime, mem_mtimecmp  in  64 each  timer values; MTIP = (mem_mtime >= mem_mtimecmp), unsigned.
REQ-013 illegal_instruction, ecall, mret, sret  in  1 each  event strobes for the current instruction.
REQ-014 rd_data  out  XLEN  combinational read of CSR at addr.
REQ-015 mepc, sepc  out  XLEN  current register values.
REQ-016 trap  out  1  combinational; high when a trap is taken this cycle.
REQ-017 privilege_mode  out  2  current mode: 00 U, 01 S, 11 M.

Function
REQ-018 Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, sstatus 0x100, sie 0x104, stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142, sip 0x144. Other addresses: read 0, writes ignored.
REQ-019 mstatus fields: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. All other bits read 0.
REQ-020 MPP is WARL: a write of 10 leaves MPP unchanged.
REQ-021 sstatus is a view of mstatus bits 1, 5 and 8. Writes affect only those bits.
REQ-022 mie bits: SSIE[1], MSIE[3], STIE[5], MTIE[7], SEIE[9], MEIE[11]. sie reads and writes only bits 1, 5, 9 of mie; sie reads 0 in bits 3, 7, 11.
REQ-023 mip read value:
- bit 1 = mem_ssip, bit 3 = mem_msip, bit 7 = MTIP, bit 11 = external_interrupt (live inputs, read-only);
- bits 5 (STIP) and 9 (SEIP) are software-writable registers.
sip reads mip bits 1, 5, 9 only and writes bits 5, 9.
REQ-024 mepc and sepc CSR writes store wr_data with bits [1:0] cleared. Trap capture stores pc unmodified.
REQ-025 mtvec, stvec, mscratch, sscratch, mcause and scause are full-width read/write.
REQ-026 Sync exception cause codes:
- illegal_instruction: cause 2;
- ecall: cause 8 + privilege_mode (11 from M, 9 from S, 8 from U);
- illegal_instruction has priority over ecall.
REQ-027 Interrupt pending = mip & mie. An interrupt is enabled when pending and (privilege_mode != M or MIE = 1).
REQ-028 Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5). Interrupt mcause = {1, code}; the MSB is XLEN-1.
REQ-029 trap = illegal_instruction | ecall | enabled interrupt. Sync exceptions take priority over interrupts.
REQ-030 All traps go to M mode; there is no delegation. On a trap the following update at the clock edge:
- mepc <= pc;
- mcause <= cause;
- MPIE <= MIE, MIE <= 0;
- MPP <= privilege_mode, privilege_mode <= 11.
Supervisor CSRs are not touched by a trap.
REQ-031 mret, with no trap: MIE <= MPIE, MPIE <= 1, privilege_mode <= MPP. MPP is unchanged.
REQ-032 sret, with no trap: SIE <= SPIE, SPIE <= 1, privilege_mode <= {0, SPP}, SPP <= 1.
REQ-033 mret and sret execute regardless of current privilege; legality checking is external.
REQ-034 Simultaneous events:
- trap beats mret/sret;
- mret beats sret;
- a trap, mret or sret in the same cycle as wr_en suppresses the CSR write.

Reset
REQ-035 Reset values:
- privilege_mode = 11;
- all CSR storage = 0, so mstatus, mie, writable mip bits, mtvec, mscratch, mepc, mcause, stvec, sscratch, sepc, scause = 0;
- trap depends only on the inputs.

Verification
REQ-036 Write mie 0x888 -> mie reads 0x888. Then write sie 0x222 -> sie reads 0x222 with bits 3, 7, 11 = 0.
REQ-037 Write mstatus MIE=1, MPIE=1, MPP=01, then pulse external_interrupt one cycle, with MEIE=1 and privilege M:
- trap = 1 that cycle;
- mstatus then reads MIE=0, MPIE=1, MPP=11.
Then mret -> MIE=1, MPIE=1, MPP=11.
REQ-038 Write sstatus SIE=1, SPIE=1, SPP=0, then sret:
- sstatus reads SIE=1, SPIE=1, SPP=1;
- privilege_mode = 00.
Then mret with MPP=11 -> privilege_mode = 11.
REQ-039 Write mip 0, then drive mem_ssip=1, mem_msip=1, mtime=2 > mtimecmp=1, external_interrupt=1 -> mip reads 0x88A. Then write sip 0x220 -> sip reads 0x222.
REQ-040 mepc and mcause, in M mode:
- ecall with pc=0xAA -> mepc reads 0xAA, mcause reads 11;
- write mepc all-ones -> reads all-ones with bits [1:0] = 0;
- illegal_instruction -> mcause reads 2;
- write mcause 5 -> reads 5;
- scause stays 0 throughout.
